// File: rtl/dac_sample_pacer.sv
// Paces a bursty 8-bit sample stream out to a DAC at one sample every DIV clocks.
// A FIFO absorbs the bursts; playout starts on prefill and falls back to IDLE on underflow.
module dac_sample_pacer #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter int          PREFILL   = 8,
  parameter int          DIV       = 50,
  parameter logic [7:0]  IDLE_CODE = 8'd128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          clr_err,
  output logic [7:0]    dac_data,
  output logic          dac_update,
  output logic [AW:0]   fifo_level,
  output logic          playing,
  output logic          overflow,
  output logic          underflow
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            tick;
  logic            pop;
  logic            push;
  logic            drop;
  logic [AW:0]     level_next;

  // A push is still accepted when full if the same edge pops, so the level never exceeds DEPTH.
  always_comb begin
    tick       = (state == PLAY) && (cnt == CW'(DIV - 1));
    pop        = tick && (fifo_level != '0);
    push       = in_valid && ((fifo_level != (AW+1)'(DEPTH)) || pop);
    drop       = in_valid && !push;
    level_next = fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  assign playing = (state == PLAY);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      dac_data   <= IDLE_CODE;
      dac_update <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      fifo_level <= level_next;
      dac_update <= pop;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        dac_data <= mem[rd_ptr];
      end

      // Error flags are sticky; a new error in the clearing cycle keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (tick && !pop) underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (level_next >= (AW+1)'(PREFILL)) state <= PLAY;
        end
        PLAY: begin
          if (tick) begin
            cnt <= '0;
            if (!pop) state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Directed bench for dac_sample_pacer with default parameters (DEPTH 16, PREFILL 8, DIV 50).
module tb_dac_sample_pacer;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       clr_err;
  logic [7:0] dac_data;
  logic       dac_update;
  logic [4:0] fifo_level;
  logic       playing;
  logic       overflow;
  logic       underflow;

  int cmp  = 0;
  int errs = 0;

  dac_sample_pacer dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .clr_err    (clr_err),
    .dac_data   (dac_data),
    .dac_update (dac_update),
    .fifo_level (fifo_level),
    .playing    (playing),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps until dac_update is seen, returning the number of edges taken.
  task automatic wait_update(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (dac_update !== 1'b1 && n < 60);
    chk({tag, "_seen"}, 32'(dac_update), 32'd1);
  endtask

  initial begin
    int n;
    int seen;
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    clr_err  = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_dac_data", 32'(dac_data), 32'd128);
    chk("rst_dac_update", 32'(dac_update), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    rst = 1'b0;

    // Prefill: 7 bytes keep IDLE, the 8th starts playout
    for (int i = 0; i < 7; i++) begin
      push(8'hA0 + 8'(i));
      chk("pre_playing", 32'(playing), 32'd0);
      chk("pre_update", 32'(dac_update), 32'd0);
    end
    chk("pre_level7", 32'(fifo_level), 32'd7);
    chk("pre_dac_idle", 32'(dac_data), 32'd128);
    push(8'hA7);
    chk("pre_playing8", 32'(playing), 32'd1);
    chk("pre_level8", 32'(fifo_level), 32'd8);
    wait_update("first", n);
    chk("first_latency", 32'(n), 32'd50);
    chk("first_data", 32'(dac_data), 32'hA0);
    chk("first_level", 32'(fifo_level), 32'd7);
    step();
    chk("first_pulse_width", 32'(dac_update), 32'd0);

    // 16 back-to-back samples drain in order, one per DIV
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    chk("burst_level16", 32'(fifo_level), 32'd16);
    chk("burst_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      wait_update("burst", n);
      chk("burst_period", 32'(n), (i == 0) ? 32'd42 : 32'd50);
      chk("burst_data", 32'(dac_data), 32'h10 + 32'(i));
      chk("burst_level", 32'(fifo_level), 32'd15 - 32'(i));
    end

    // Overflow on the 17th byte, clear, then a push on a full tick cycle
    do_reset();
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    chk("ovf_before", 32'(overflow), 32'd0);
    push(8'h30);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    repeat (39) step();
    chk("full_pre_tick_upd", 32'(dac_update), 32'd0);
    push(8'h99);
    chk("full_tick_upd", 32'(dac_update), 32'd1);
    chk("full_tick_data", 32'(dac_data), 32'h20);
    chk("full_tick_level", 32'(fifo_level), 32'd16);
    chk("full_tick_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      wait_update("full_drain", n);
      chk("full_drain_period", 32'(n), 32'd50);
      chk("full_drain_data", 32'(dac_data), (i == 16) ? 32'h99 : 32'h20 + 32'(i));
      chk("full_drain_level", 32'(fifo_level), 32'd16 - 32'(i));
    end

    // Underflow after 8 samples with no refill, then recovery
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      wait_update("unf_play", n);
      chk("unf_play_period", 32'(n), 32'd50);
      chk("unf_play_data", 32'(dac_data), 32'h40 + 32'(i));
    end
    seen = 0;
    for (int i = 0; i < 49; i++) begin
      step();
      if (dac_update === 1'b1) seen++;
    end
    chk("unf_quiet", 32'(seen), 32'd0);
    chk("unf_before", 32'(underflow), 32'd0);
    step();
    chk("unf_set", 32'(underflow), 32'd1);
    chk("unf_playing", 32'(playing), 32'd0);
    chk("unf_hold", 32'(dac_data), 32'h47);
    chk("unf_no_update", 32'(dac_update), 32'd0);
    chk("unf_level", 32'(fifo_level), 32'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("unf_clr", 32'(underflow), 32'd0);
    for (int i = 0; i < 7; i++) push(8'h50 + 8'(i));
    chk("refill_idle", 32'(playing), 32'd0);
    push(8'h57);
    chk("refill_play", 32'(playing), 32'd1);
    wait_update("refill", n);
    chk("refill_latency", 32'(n), 32'd50);
    chk("refill_data", 32'(dac_data), 32'h50);

    // Asynchronous reset mid-playout with level 5
    do_reset();
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) wait_update("mid", n);
    chk("mid_level5", 32'(fifo_level), 32'd5);
    chk("mid_data", 32'(dac_data), 32'h62);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dac_data", 32'(dac_data), 32'd128);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_playing", 32'(playing), 32'd0);
    chk("arst_update", 32'(dac_update), 32'd0);
    step();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (dac_update === 1'b1 || playing === 1'b1) seen++;
    end
    chk("arst_quiet", 32'(seen), 32'd0);
    for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
    chk("arst_refill_idle", 32'(playing), 32'd0);
    push(8'h77);
    chk("arst_refill_play", 32'(playing), 32'd1);
    wait_update("arst_refill", n);
    chk("arst_refill_latency", 32'(n), 32'd50);
    chk("arst_refill_data", 32'(dac_data), 32'h70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
